// File: rtl/synth_pkg.sv
// Shared types and helpers for the poly_synth voice engine.
//   adsr_state_t : per-voice envelope FSM state
//   LfsrPoly     : Galois feedback mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
//   LfsrSeed     : LFSR reset value
//   sat_add      : min(a+b, lim)
//   sat_sub      : max(a-b, lo)
// Arguments are zero-extended into 32 bits; callers truncate back to EW bits.
package synth_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAttack,
    StDecay,
    StSustain,
    StRelease
  } adsr_state_t;

  localparam logic [15:0] LfsrPoly = 16'hB400;
  localparam logic [15:0] LfsrSeed = 16'hACE1;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] lim);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum >= {1'b0, lim}) ? lim : sum[31:0];
  endfunction

  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] lo);
    // Compare before subtracting so a < b cannot wrap.
    logic [32:0] need;
    need = {1'b0, b} + {1'b0, lo};
    return ({1'b0, a} >= need) ? (a - b) : lo;
  endfunction

endpackage

// File: rtl/synth_voice.sv
// One synthesiser voice: gate edge detect, ADSR envelope FSM and free-running pulse oscillator.
// Ports:
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   tick_i         : envelope update strobe from the shared prescaler
//   trig_i         : level-sensitive gate
//   ai_i/di_i/ri_i : attack/decay/release step per tick (0 behaves as 1)
//   s_i            : sustain level
//   count_max_i    : oscillator half period minus one
//   env_o, phase_o : current envelope level and oscillator phase
//   busy_o         : state is not idle
module synth_voice
  import synth_pkg::*;
#(
  parameter int unsigned EW = 8,
  parameter int unsigned CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          tick_i,
  input  logic          trig_i,
  input  logic [EW-1:0] ai_i,
  input  logic [EW-1:0] di_i,
  input  logic [EW-1:0] s_i,
  input  logic [EW-1:0] ri_i,
  input  logic [CW-1:0] count_max_i,
  output logic [EW-1:0] env_o,
  output logic          phase_o,
  output logic          busy_o
);

  localparam logic [EW-1:0] EnvMax = '1;

  adsr_state_t   state_q, state_d;
  logic [EW-1:0] env_q, env_d;
  logic          trig_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  logic [EW-1:0] step_a, step_d, step_r;
  logic          rise, wrap;

  assign step_a = (ai_i == '0) ? EW'(1) : ai_i;
  assign step_d = (di_i == '0) ? EW'(1) : di_i;
  assign step_r = (ri_i == '0) ? EW'(1) : ri_i;
  assign rise   = trig_i & ~trig_q;

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    // A rising gate restarts the attack from the current level in every state.
    if (rise) begin
      state_d = StAttack;
    end else begin
      case (state_q)
        StIdle: ;
        StAttack: begin
          if (!trig_i) begin
            state_d = StRelease;
          end else if (tick_i) begin
            env_d = EW'(sat_add(32'(env_q), 32'(step_a), 32'(EnvMax)));
            if (env_d == EnvMax) state_d = StDecay;
          end
        end
        StDecay: begin
          if (!trig_i) begin
            state_d = StRelease;
          end else if (s_i == EnvMax) begin
            state_d = StSustain;
            env_d   = EnvMax;
          end else if (tick_i) begin
            env_d = EW'(sat_sub(32'(env_q), 32'(step_d), 32'(s_i)));
            if (env_d == s_i) state_d = StSustain;
          end
        end
        StSustain: begin
          if (!trig_i) state_d = StRelease;
          else         env_d   = s_i;
        end
        StRelease: begin
          if (tick_i) begin
            env_d = EW'(sat_sub(32'(env_q), 32'(step_r), 32'd0));
            if (env_d == '0) state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // >= rather than == so a lowered count_max wraps at once instead of overrunning.
  assign wrap    = (cnt_q >= count_max_i);
  assign cnt_d   = wrap ? '0 : cnt_q + CW'(1);
  assign phase_d = phase_q ^ wrap;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      env_q   <= '0;
      trig_q  <= 1'b0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      trig_q  <= trig_i;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign env_o   = env_q;
  assign phase_o = phase_q;
  assign busy_o  = (state_q != StIdle);

endmodule

// File: rtl/poly_synth.sv
// Multi-voice pulse/ADSR synthesiser with a registered signed mixer output.
// Ports:
//   clk, rst   : clock, synchronous active-low reset
//   trig       : per-voice gate
//   ai/di/s/ri : shared ADSR timing and sustain level
//   count_max  : per-voice half period minus one, voice v at [v*CW +: CW]
//   noise_sel  : per-voice LFSR-noise select (only with POLY_SYNTH_NOISE_EN)
//   busy       : per-voice "not idle"
//   data       : signed mixed sample, one clock behind the voice state
// Build option: define POLY_SYNTH_NOISE_EN to add noise_sel and the shared 16-bit LFSR.
module poly_synth
  import synth_pkg::*;
#(
  parameter int unsigned VOICES  = 4,
  parameter int unsigned EW      = 8,
  parameter int unsigned CW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned ENV_DIV = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [VOICES-1:0]    trig,
  input  logic [EW-1:0]        ai,
  input  logic [EW-1:0]        di,
  input  logic [EW-1:0]        s,
  input  logic [EW-1:0]        ri,
  input  logic [VOICES*CW-1:0] count_max,
`ifdef POLY_SYNTH_NOISE_EN
  input  logic [VOICES-1:0]    noise_sel,
`endif
  output logic [VOICES-1:0]    busy,
  output logic [DW-1:0]        data
);

  localparam int unsigned SW    = EW + 1 + $clog2(VOICES);
  localparam int unsigned Shift = DW - SW;
  localparam int unsigned PW    = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  assign tick    = (presc_q == PW'(ENV_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  logic [EW-1:0]     env_v [VOICES];
  logic [VOICES-1:0] phase_v;
  logic [VOICES-1:0] sign_v;

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    synth_voice #(
      .EW(EW),
      .CW(CW)
    ) u_voice (
      .clk_i       (clk),
      .rst_ni      (rst),
      .tick_i      (tick),
      .trig_i      (trig[v]),
      .ai_i        (ai),
      .di_i        (di),
      .s_i         (s),
      .ri_i        (ri),
      .count_max_i (count_max[v*CW +: CW]),
      .env_o       (env_v[v]),
      .phase_o     (phase_v[v]),
      .busy_o      (busy[v])
    );
  end

`ifdef POLY_SYNTH_NOISE_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrPoly : 16'h0000);
  assign sign_v = (noise_sel & {VOICES{lfsr_q[0]}}) | (~noise_sel & phase_v);

  always_ff @(posedge clk) begin
    if (!rst) lfsr_q <= LfsrSeed;
    else      lfsr_q <= lfsr_d;
  end
`else
  assign sign_v = phase_v;
`endif

  logic signed [SW-1:0] sum;
  logic        [DW-1:0] data_d, data_q;

  always_comb begin
    logic signed [EW:0] samp;
    samp = '0;
    sum  = '0;
    for (int v = 0; v < VOICES; v++) begin
      samp = $signed({1'b0, env_v[v]});
      if (!sign_v[v]) samp = -samp;
      sum = sum + SW'(samp);
    end
    // Scale the mix so full-scale voices land near the top of the output range.
    data_d = DW'(sum) << Shift;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q <= '0;
      data_q  <= '0;
    end else begin
      presc_q <= presc_d;
      data_q  <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: tb/tb_poly_synth.sv
// Scoreboard bench for poly_synth: the stimulus process queues expected observations stamped with
// the clock cycle they belong to; the monitor pops and compares them on the falling edge.
module tb_poly_synth;

  logic        clk;
  logic        rst, rst2;
  logic [3:0]  trig, trig2;
  logic [7:0]  ai, di, s, ri;
  logic [7:0]  ai2;
  logic [63:0] cm, cm2;
  logic [3:0]  busy, busy2;
  logic [15:0] data, data2;
  logic [3:0]  noise_sel, noise_sel2;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int          cyc;
    int          kind;   // 0 data, 1 busy, 2 data of dut2, 3 busy of dut2
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  poly_synth dut (
    .clk       (clk),
    .rst       (rst),
    .trig      (trig),
    .ai        (ai),
    .di        (di),
    .s         (s),
    .ri        (ri),
    .count_max (cm),
`ifdef POLY_SYNTH_NOISE_EN
    .noise_sel (noise_sel),
`endif
    .busy      (busy),
    .data      (data)
  );

  poly_synth #(.ENV_DIV(4)) dut2 (
    .clk       (clk),
    .rst       (rst2),
    .trig      (trig2),
    .ai        (ai2),
    .di        (di),
    .s         (s),
    .ri        (ri),
    .count_max (cm2),
`ifdef POLY_SYNTH_NOISE_EN
    .noise_sel (noise_sel2),
`endif
    .busy      (busy2),
    .data      (data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  exp_t        it;
  logic [15:0] act;
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      it = sb_q.pop_front();
      case (it.kind)
        0:       act = data;
        1:       act = {12'h000, busy};
        2:       act = data2;
        default: act = {12'h000, busy2};
      endcase
      checks++;
      if (it.cyc != cyc) begin
        failures++;
        $display("FAIL %s: check for cycle %0d missed (now %0d)", it.name, it.cyc, cyc);
      end else if (act !== it.exp) begin
        failures++;
        $display("FAIL %s @cyc %0d: got %0d (0x%h) expected %0d (0x%h)", it.name, cyc,
                 $signed(act), act, $signed(it.exp), it.exp);
      end
    end
  end

  task automatic expect_at(input int d, input int kind, input int v, input string name);
    exp_t e;
    e.cyc  = cyc + d;
    e.kind = kind;
    e.exp  = 16'(v);
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  initial begin
    logic [15:0] l;
    rst = 1'b0;  rst2 = 1'b0;
    trig = '0;   trig2 = '0;
    ai = 8'd5;   di = 8'd10; s = 8'd64; ri = 8'd1;
    ai2 = 8'd0;
    cm  = {4{16'hFFFF}};
    cm2 = {{3{16'hFFFF}}, 16'd100};
    noise_sel = '0; noise_sel2 = '0;

    // Reset state
    step(3);
    expect_at(0, 0, 0, "reset_data");
    expect_at(0, 1, 0, "reset_busy");
    step(1);

    // Voice 0 full ADSR cycle; phase held at 0 so data = -env*32
    rst = 1'b1; trig = 4'b0001;
    expect_at(1,  1, 1,     "attack_busy");
    expect_at(52, 0, -8000, "attack_250");
    expect_at(53, 0, -8160, "attack_max");
    expect_at(72, 0, -2080, "decay_65");
    expect_at(73, 0, -2048, "decay_to_sustain");
    expect_at(80, 0, -2048, "sustain_hold");
    step(80);
    trig = 4'b0000;
    expect_at(1,  1, 1,   "release_busy");
    expect_at(64, 1, 1,   "release_last_busy");
    expect_at(65, 0, -32, "release_env1");
    expect_at(65, 1, 0,   "release_idle");
    expect_at(66, 0, 0,   "release_zero");
    step(70);

    // Voice 1 retrigger from RELEASE resumes at the current level
    trig = 4'b0010;
    expect_at(8,  0, -960,  "pre_release_30");
    expect_at(8,  1, 2,     "retrig_busy");
    expect_at(9,  0, -960,  "release_entry_30");
    expect_at(10, 0, -960,  "retrig_edge_30");
    expect_at(11, 0, -1120, "retrig_35");
    step(7);
    trig = 4'b0000;
    step(1);
    trig = 4'b0010;
    step(15);

    // Reset mid-attack (env 100), gate held high across reset release
    rst = 1'b0;
    expect_at(0, 0, -3040, "pre_reset_95");
    expect_at(1, 0, 0,     "midreset_data");
    expect_at(1, 1, 0,     "midreset_busy");
    step(1);
    rst = 1'b1;
    expect_at(1, 1, 2,    "post_reset_attack");
    expect_at(2, 0, 0,    "post_reset_env0");
    expect_at(3, 0, -160, "post_reset_env5");
    step(5);

    // All voices, count_max=2 (phase period 6), sustain at 64
    rst = 1'b0; trig = '0; cm = {4{16'd2}};
    step(1);
    rst = 1'b1; trig = 4'hF;
    expect_at(73, 0, -8192, "mix_neg_a");
    expect_at(76, 0, 8192,  "mix_pos_a");
    expect_at(78, 0, 8192,  "mix_pos_b");
    expect_at(79, 0, -8192, "mix_neg_b");
    expect_at(80, 1, 15,    "mix_busy_all");
    step(82);
    rst = 1'b0; trig = '0; cm = {4{16'hFFFF}};
    step(1);

    // ENV_DIV=4 with ai=0, then count_max lowered below the running counter
    rst2 = 1'b1; trig2 = 4'b0001;
    expect_at(1,  3, 1,    "div4_busy");
    expect_at(4,  2, 0,    "div4_env0");
    expect_at(5,  2, -32,  "div4_env1");
    expect_at(8,  2, -32,  "div4_env1_hold");
    expect_at(9,  2, -64,  "div4_env2");
    expect_at(51, 2, -384, "cm_before");
    expect_at(52, 2, 384,  "cm_lowered_toggle");
    expect_at(55, 2, 416,  "cm3_phase1");
    expect_at(56, 2, -416, "cm3_toggle");
    step(50);
    cm2 = {{3{16'hFFFF}}, 16'd3};
    step(10);

`ifdef POLY_SYNTH_NOISE_EN
    // Voice 2 sign driven by the LFSR once sustained at 64
    noise_sel = 4'b0100; trig = '0;
    step(1);
    rst = 1'b1; trig = 4'b0100;
    l = 16'hACE1;
    for (int i = 0; i < 80; i++) l = lfsr_next(l);
    for (int i = 0; i < 8; i++) begin
      expect_at(81 + i, 0, l[0] ? 2048 : -2048, "noise_sign");
      l = lfsr_next(l);
    end
    step(92);
`endif

    step(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
